// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: LEGv8 immediate decode/extend into a small FIFO.
// Optional IMMEXT_BRANCH_SHIFT_EN adds imm_sh (branch offset << 2).
module imm_extend_pipe #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        itype
`ifdef IMMEXT_BRANCH_SHIFT_EN
  ,
  output logic [DATA_W-1:0] imm_sh
`endif
);

  typedef enum logic [2:0] {
    IT_NONE = 3'd0,
    IT_R    = 3'd1,
    IT_D    = 3'd2,
    IT_CB   = 3'd3,
    IT_B    = 3'd4,
    IT_I    = 3'd5
  } itype_e;

  // Two physical slots; DEPTH only caps occupancy.
  localparam int SLOTS = 2;
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;

  logic is_r;
  logic is_d;
  logic is_cb;
  logic is_b;
  logic is_i;

  logic [DATA_W-1:0] d_imm;
  itype_e            d_ity;
`ifdef IMMEXT_BRANCH_SHIFT_EN
  logic [DATA_W-1:0] d_sh;
`endif

  logic [DATA_W-1:0] mem_imm [SLOTS];
  itype_e            mem_ity [SLOTS];
`ifdef IMMEXT_BRANCH_SHIFT_EN
  logic [DATA_W-1:0] mem_sh  [SLOTS];
`endif

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Register fields are not part of any immediate.
  logic unused_rd;
  assign unused_rd = ^instr[4:0];

  assign op11 = instr[31:21];
  assign op10 = instr[31:22];
  assign op8  = instr[31:24];
  assign op6  = instr[31:26];

  assign is_r = (op11 == 11'b11010011011)
             || (op11 == 11'b11010011010)
             || (op11 == 11'b10011011000)
             || (op11 == 11'b10101011000)
             || (op11 == 11'b11101011000);

  assign is_d = (op11 == 11'b11111000010)
             || (op11 == 11'b11111000000);

  assign is_cb = (op8 == 8'b01010100)
              || (op8 == 8'b10110100);

  assign is_b = (op6 == 6'b000101);

  assign is_i = (op10 == 10'b1001000100)
             || (op10 == 10'b1101000100);

  // First matching class wins; unknown encodings yield zero.
  always_comb begin
    d_imm = '0;
    d_ity = IT_NONE;
    priority case (1'b1)
      is_r: begin
        d_imm = {{(DATA_W-6){1'b0}}, instr[15:10]};
        d_ity = IT_R;
      end
      is_d: begin
        d_imm = {{(DATA_W-9){instr[20]}}, instr[20:12]};
        d_ity = IT_D;
      end
      is_cb: begin
        d_imm = {{(DATA_W-19){instr[23]}}, instr[23:5]};
        d_ity = IT_CB;
      end
      is_b: begin
        d_imm = {{(DATA_W-26){instr[25]}}, instr[25:0]};
        d_ity = IT_B;
      end
      is_i: begin
        d_imm = {{(DATA_W-12){1'b0}}, instr[21:10]};
        d_ity = IT_I;
      end
      default: ;
    endcase
  end

`ifdef IMMEXT_BRANCH_SHIFT_EN
  // Branch offsets are word offsets; scale to bytes.
  always_comb begin
    d_sh = d_imm;
    if (d_ity == IT_CB || d_ity == IT_B)
      d_sh = d_imm << 2;
  end
`endif

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign imm   = mem_imm[rd_ptr];
  assign itype = mem_ity[rd_ptr];
`ifdef IMMEXT_BRANCH_SHIFT_EN
  assign imm_sh = mem_sh[rd_ptr];
`endif

  function automatic logic nxt(input logic p);
    return (DEPTH_C == 2'd2) ? ~p : 1'b0;
  endfunction

  // Pointer/count bookkeeping and slot writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        mem_imm[i] <= '0;
        mem_ity[i] <= IT_NONE;
`ifdef IMMEXT_BRANCH_SHIFT_EN
        mem_sh[i]  <= '0;
`endif
      end
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= d_imm;
        mem_ity[wr_ptr] <= d_ity;
`ifdef IMMEXT_BRANCH_SHIFT_EN
        mem_sh[wr_ptr]  <= d_sh;
`endif
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed vectors plus FIFO corner sequences.
// Two DUTs: DATA_W 64 / DEPTH 2 and DATA_W 32 / DEPTH 1.
module tb_imm_extend_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  logic        ir64;
  logic        ov64;
  logic [63:0] imm64;
  logic [2:0]  ity64;
  logic        ir32;
  logic        ov32;
  logic [31:0] imm32;
  logic [2:0]  ity32;
`ifdef IMMEXT_BRANCH_SHIFT_EN
  logic [63:0] sh64;
  logic [31:0] sh32;
`endif

  int total;
  int bad;

  imm_extend_pipe #(.DATA_W(64), .DEPTH(2)) u64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir64),
    .instr(instr), .out_valid(ov64),
    .out_ready(out_ready), .imm(imm64),
    .itype(ity64)
`ifdef IMMEXT_BRANCH_SHIFT_EN
    , .imm_sh(sh64)
`endif
  );

  imm_extend_pipe #(.DATA_W(32), .DEPTH(1)) u32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir32),
    .instr(instr), .out_valid(ov32),
    .out_ready(out_ready), .imm(imm32),
    .itype(ity32)
`ifdef IMMEXT_BRANCH_SHIFT_EN
    , .imm_sh(sh32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  ity;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] shx(input vec_t x);
    return (x.ity == 3'd3 || x.ity == 3'd4) ? x.imm << 2 : x.imm;
  endfunction

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    instr = '0;
    out_ready = 1'b0;

    v[0]  = '{{11'b11111000010, 9'h1FF, 2'b00, 5'd1, 5'd2},
              64'hFFFF_FFFF_FFFF_FFFF, 3'd2};
    v[1]  = '{{11'b11111000000, 9'h0FF, 12'h000},
              64'h0000_0000_0000_00FF, 3'd2};
    v[2]  = '{{6'b000101, 26'h200_0000},
              64'hFFFF_FFFF_FE00_0000, 3'd4};
    v[3]  = '{{6'b000101, 26'h123_4567},
              64'h0000_0000_0123_4567, 3'd4};
    v[4]  = '{{8'b01010100, 19'h7FFFF, 5'h0},
              64'hFFFF_FFFF_FFFF_FFFF, 3'd3};
    v[5]  = '{{8'b10110100, 19'h00010, 5'd3},
              64'h0000_0000_0000_0010, 3'd3};
    v[6]  = '{{10'b1001000100, 12'hFFF, 10'h000},
              64'h0000_0000_0000_0FFF, 3'd5};
    v[7]  = '{{10'b1101000100, 12'h123, 10'h3FF},
              64'h0000_0000_0000_0123, 3'd5};
    v[8]  = '{{11'b11010011011, 5'h0, 6'h3F, 10'h000},
              64'h0000_0000_0000_003F, 3'd1};
    v[9]  = '{{11'b10011011000, 5'h1F, 6'h15, 10'h155},
              64'h0000_0000_0000_0015, 3'd1};
    v[10] = '{{11'b11101011000, 5'h0, 6'h2A, 10'h000},
              64'h0000_0000_0000_002A, 3'd1};
    v[11] = '{{11'b11010011010, 5'h0, 6'h01, 10'h000},
              64'h0000_0000_0000_0001, 3'd1};
    v[12] = '{{11'b10101011000, 5'h0, 6'h20, 10'h000},
              64'h0000_0000_0000_0020, 3'd1};
    v[13] = '{32'h0000_0000, 64'h0, 3'd0};
    v[14] = '{32'hFFFF_FFFF, 64'h0, 3'd0};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst ov64", 64'(ov64), 64'd0);
    chk("rst ir64", 64'(ir64), 64'd1);
    chk("rst imm64", imm64, 64'd0);
    chk("rst ity64", 64'(ity64), 64'd0);
    chk("rst ov32", 64'(ov32), 64'd0);
    chk("rst ir32", 64'(ir32), 64'd1);
`ifdef IMMEXT_BRANCH_SHIFT_EN
    chk("rst sh64", sh64, 64'd0);
`endif

    // one push, check next cycle, then pop
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      instr = v[i].instr;
      out_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d ov64", i), 64'(ov64), 64'd1);
      chk($sformatf("v%0d imm64", i), imm64, v[i].imm);
      chk($sformatf("v%0d ity64", i), 64'(ity64), 64'(v[i].ity));
      chk($sformatf("v%0d imm32", i), 64'(imm32),
          64'(v[i].imm[31:0]));
      chk($sformatf("v%0d ity32", i), 64'(ity32), 64'(v[i].ity));
`ifdef IMMEXT_BRANCH_SHIFT_EN
      chk($sformatf("v%0d sh64", i), sh64, shx(v[i]));
      chk($sformatf("v%0d sh32", i), 64'(sh32),
          64'(shx(v[i]) & 64'hFFFF_FFFF));
`endif
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d empty", i), 64'(ov64), 64'd0);
      out_ready = 1'b0;
    end

    // fill with out_ready low, third push refused
    in_valid = 1'b1;
    instr = v[0].instr;
    chk("fill ir1", 64'(ir64), 64'd1);
    @(negedge clk);
    instr = v[2].instr;
    chk("fill ir2", 64'(ir64), 64'd1);
    chk("fill head1", imm64, v[0].imm);
    @(negedge clk);
    instr = v[6].instr;
    chk("fill ir3", 64'(ir64), 64'd0);
    chk("fill head2", imm64, v[0].imm);
    chk("fill ir32", 64'(ir32), 64'd0);
    @(negedge clk);
    chk("hold imm", imm64, v[0].imm);
    chk("hold ity", 64'(ity64), 64'd2);
    chk("hold ir", 64'(ir64), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain ov", 64'(ov64), 64'd1);
    chk("drain imm", imm64, v[2].imm);
    chk("drain ity", 64'(ity64), 64'd4);
    @(negedge clk);
    chk("drain empty", 64'(ov64), 64'd0);
    chk("drain ir", 64'(ir64), 64'd1);

    // one push per cycle with out_ready high
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      instr = v[k+6].instr;
      chk($sformatf("tp%0d ir", k), 64'(ir64), 64'd1);
      if (k > 0) begin
        chk($sformatf("tp%0d ov", k), 64'(ov64), 64'd1);
        chk($sformatf("tp%0d imm", k), imm64, v[k+5].imm);
      end
      if (k == 1)
        chk("tp ir32 full", 64'(ir32), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("tp last ov", 64'(ov64), 64'd1);
    chk("tp last imm", imm64, v[10].imm);
    @(negedge clk);
    chk("tp empty", 64'(ov64), 64'd0);
    repeat (2) @(negedge clk);
    out_ready = 1'b0;

    // flush while full, with in_valid high
    in_valid = 1'b1;
    instr = v[0].instr;
    @(negedge clk);
    instr = v[1].instr;
    @(negedge clk);
    flush = 1'b1;
    instr = v[6].instr;
    chk("fl full ir", 64'(ir64), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl ov", 64'(ov64), 64'd0);
    chk("fl ir", 64'(ir64), 64'd1);
    chk("fl ov32", 64'(ov32), 64'd0);
    @(negedge clk);
    chk("fl ov later", 64'(ov64), 64'd0);

    // flush with room left: the same-cycle push is dropped
    in_valid = 1'b1;
    instr = v[2].instr;
    @(negedge clk);
    flush = 1'b1;
    instr = v[6].instr;
    chk("fl2 ir", 64'(ir64), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2 ov", 64'(ov64), 64'd0);
    @(negedge clk);
    chk("fl2 ov later", 64'(ov64), 64'd0);

    // order survives after flush
    in_valid = 1'b1;
    instr = v[3].instr;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pf ov", 64'(ov64), 64'd1);
    chk("pf imm", imm64, v[3].imm);
    out_ready = 1'b1;
    @(negedge clk);
    chk("pf empty", 64'(ov64), 64'd0);
    out_ready = 1'b0;

    // reset mid-stream
    in_valid = 1'b1;
    instr = v[0].instr;
    @(negedge clk);
    instr = v[2].instr;
    @(negedge clk);
    reset = 1'b1;
    instr = v[6].instr;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("mr ov", 64'(ov64), 64'd0);
    chk("mr ir", 64'(ir64), 64'd1);
    chk("mr imm", imm64, 64'd0);
    chk("mr ity", 64'(ity64), 64'd0);
    chk("mr ov32", 64'(ov32), 64'd0);
    @(negedge clk);
    chk("mr ov later", 64'(ov64), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
